// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with the EX/MEM register, a byte-lane data RAM and the MEM/WB register.
// Latency: EX fields are captured on edge k. The RAM access and the MEM/WB capture happen on edge k+1.
// Backpressure: i_stall freezes both pipeline registers, the RAM write and the read latch. i_flush (when not stalled) loads a bubble.
//
// Ports
//   i_clk, i_rst_n         clock (rising edge) and asynchronous active-low reset
//   i_stall, i_flush       pipeline hold / EX/MEM bubble insert
//   i_valid .. i_mem_to_reg  EX-stage instruction fields (address, store data, dest, controls)
//   o_fwd_*                EX/MEM forwarding taps (registered, no extra latency)
//   o_valid .. o_misaligned  MEM/WB outputs towards write-back
// Optional build macro MEM_DEBUG_PORT_EN adds i_dbg_addr/o_dbg_data.
// That pair is a read-only second RAM port with one cycle of latency, and it ignores i_stall.
module mem_stage #(
  parameter int SIZE    = 32,
  parameter int ADDR_W  = 8,
  parameter int REG_ADD = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
`ifdef MEM_DEBUG_PORT_EN
  input  logic [ADDR_W-1:0]  i_dbg_addr,
  output logic [SIZE-1:0]    o_dbg_data,
`endif
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [SIZE-1:0]    i_alu_res,
  input  logic [SIZE-1:0]    i_store_data,
  input  logic [REG_ADD-1:0] i_reg_add,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [1:0]         i_mem_width,
  input  logic               i_mem_unsigned,
  input  logic               i_reg_write,
  input  logic               i_mem_to_reg,
  output logic [SIZE-1:0]    o_fwd_alu_res,
  output logic [REG_ADD-1:0] o_fwd_reg_add,
  output logic               o_fwd_reg_write,
  output logic               o_valid,
  output logic [SIZE-1:0]    o_read_data,
  output logic [SIZE-1:0]    o_alu_res,
  output logic [REG_ADD-1:0] o_reg_add,
  output logic               o_reg_write,
  output logic               o_mem_to_reg,
  output logic               o_misaligned
);

  localparam int DEPTH = 2 ** ADDR_W;

  // EX/MEM register contents
  typedef struct packed {
    logic               valid;
    logic [SIZE-1:0]    alu_res;
    logic [SIZE-1:0]    store_data;
    logic [REG_ADD-1:0] reg_add;
    logic               mem_read;
    logic               mem_write;
    logic [1:0]         width;
    logic               load_unsigned;
    logic               reg_write;
    logic               mem_to_reg;
  } ex_mem_t;

  // MEM/WB register contents. The load lane info is kept so that the extension can be done after the RAM read latch.
  typedef struct packed {
    logic               valid;
    logic [SIZE-1:0]    alu_res;
    logic [REG_ADD-1:0] reg_add;
    logic               reg_write;
    logic               mem_to_reg;
    logic               misaligned;
    logic               load;
    logic [1:0]         lane;
    logic [1:0]         width;
    logic               load_unsigned;
  } mem_wb_t;

  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;

  // ---------------------------------------------------------------
  // EX/MEM register
  // ---------------------------------------------------------------
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!i_stall) begin
      if (i_flush) begin
        // Bubble: the whole entry is cleared, so valid and every control bit drop together.
        ex_mem_d = '0;
      end else begin
        ex_mem_d.valid         = i_valid;
        ex_mem_d.alu_res       = i_alu_res;
        ex_mem_d.store_data    = i_store_data;
        ex_mem_d.reg_add       = i_reg_add;
        ex_mem_d.mem_read      = i_mem_read;
        ex_mem_d.mem_write     = i_mem_write;
        ex_mem_d.width         = i_mem_width;
        ex_mem_d.load_unsigned = i_mem_unsigned;
        ex_mem_d.reg_write     = i_reg_write;
        ex_mem_d.mem_to_reg    = i_mem_to_reg;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  // ---------------------------------------------------------------
  // Access decode on the registered address
  // ---------------------------------------------------------------
  logic [1:0]        byte_off;
  logic              is_word;
  logic              is_half;
  logic              mem_access;
  logic              misaligned;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [SIZE-1:0]   ram_wdata;

  assign byte_off   = ex_mem_q.alu_res[1:0];
  assign is_word    = ex_mem_q.width[1];              // 10 and 11 both mean word
  assign is_half    = (ex_mem_q.width == 2'b01);
  assign mem_access = ex_mem_q.valid & (ex_mem_q.mem_read | ex_mem_q.mem_write);
  assign misaligned = mem_access &
                      ((is_half & byte_off[0]) | (is_word & (byte_off != 2'b00)));
  // Address bits above the RAM range are dropped, so accesses wrap.
  assign ram_addr   = ex_mem_q.alu_res[ADDR_W+1:2];
  assign ram_we     = ex_mem_q.valid & ex_mem_q.mem_write & ~misaligned & ~i_stall;

  // Sub-word store data is replicated to every lane. The byte enable then picks the lane.
  always_comb begin
    ram_wdata = ex_mem_q.store_data;
    ram_be    = 4'hF;
    if (is_half) begin
      ram_wdata = {2{ex_mem_q.store_data[15:0]}};
      ram_be    = 4'b0011 << byte_off;
    end else if (!is_word) begin
      ram_wdata = {4{ex_mem_q.store_data[7:0]}};
      ram_be    = 4'b0001 << byte_off;
    end
  end

  // ---------------------------------------------------------------
  // Data RAM: synchronous byte-lane write and synchronous read
  // ---------------------------------------------------------------
  logic [SIZE-1:0] ram_q [DEPTH];
  logic [SIZE-1:0] rd_word_q;

  // A slot is either a load or a store, never both.
  // The word a store reads back is therefore never used.
  // A load in the following slot sees the value committed on this edge.
  // The read latch follows the stall, so o_read_data stays frozen during a hold.
  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) begin
          ram_q[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
    if (!i_stall) begin
      rd_word_q <= ram_q[ram_addr];
    end
  end

`ifdef MEM_DEBUG_PORT_EN
  // Debug read port. It runs freely and keeps running while the pipeline is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dbg_data <= '0;
    end else begin
      o_dbg_data <= ram_q[i_dbg_addr];
    end
  end
`endif

  // ---------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------
  always_comb begin
    mem_wb_d               = '0;
    mem_wb_d.valid         = ex_mem_q.valid;
    mem_wb_d.alu_res       = ex_mem_q.alu_res;
    mem_wb_d.reg_add       = ex_mem_q.reg_add;
    mem_wb_d.reg_write     = ex_mem_q.valid & ex_mem_q.reg_write & ~misaligned;
    mem_wb_d.mem_to_reg    = ex_mem_q.valid & ex_mem_q.mem_to_reg;
    mem_wb_d.misaligned    = misaligned;
    mem_wb_d.load          = ex_mem_q.valid & ex_mem_q.mem_read & ~misaligned;
    mem_wb_d.lane          = byte_off;
    mem_wb_d.width         = ex_mem_q.width;
    mem_wb_d.load_unsigned = ex_mem_q.load_unsigned;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_wb_q <= '0;
    end else if (!i_stall) begin
      mem_wb_q <= mem_wb_d;
    end
  end

  // ---------------------------------------------------------------
  // Load lane select and extension
  // ---------------------------------------------------------------
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [SIZE-1:0] read_data;

  always_comb begin
    case (mem_wb_q.lane)
      2'd0:    ld_byte = rd_word_q[7:0];
      2'd1:    ld_byte = rd_word_q[15:8];
      2'd2:    ld_byte = rd_word_q[23:16];
      default: ld_byte = rd_word_q[31:24];
    endcase
    ld_half = mem_wb_q.lane[1] ? rd_word_q[31:16] : rd_word_q[15:0];
  end

  // Non-loads, bubbles and misaligned loads return zero, so write-back never sees stale RAM data.
  always_comb begin
    read_data = '0;
    if (mem_wb_q.load) begin
      if (mem_wb_q.width[1]) begin
        read_data = rd_word_q;
      end else if (mem_wb_q.width[0]) begin
        read_data = mem_wb_q.load_unsigned ? {{(SIZE-16){1'b0}}, ld_half}
                                           : {{(SIZE-16){ld_half[15]}}, ld_half};
      end else begin
        read_data = mem_wb_q.load_unsigned ? {{(SIZE-8){1'b0}}, ld_byte}
                                           : {{(SIZE-8){ld_byte[7]}}, ld_byte};
      end
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign o_fwd_alu_res   = ex_mem_q.alu_res;
  assign o_fwd_reg_add   = ex_mem_q.reg_add;
  assign o_fwd_reg_write = ex_mem_q.reg_write & ex_mem_q.valid;

  assign o_valid      = mem_wb_q.valid;
  assign o_read_data  = read_data;
  assign o_alu_res    = mem_wb_q.alu_res;
  assign o_reg_add    = mem_wb_q.reg_add;
  assign o_reg_write  = mem_wb_q.reg_write;
  assign o_mem_to_reg = mem_wb_q.mem_to_reg;
  assign o_misaligned = mem_wb_q.misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage.
// A transaction-level model holds memory as a byte array and keeps the two pipeline slots.
// Directed cases pin the model with literal values. A randomized phase follows.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        stall, flush, valid, mem_read, mem_write, mem_unsigned, reg_write, mem_to_reg;
  logic [31:0] alu_res, store_data;
  logic [4:0]  reg_add;
  logic [1:0]  mem_width;

  logic [31:0] o_fwd_alu_res, o_read_data, o_alu_res;
  logic [4:0]  o_fwd_reg_add, o_reg_add;
  logic        o_fwd_reg_write, o_valid, o_reg_write, o_mem_to_reg, o_misaligned;

  mem_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_valid(valid),
    .i_alu_res(alu_res), .i_store_data(store_data), .i_reg_add(reg_add),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_width(mem_width),
    .i_mem_unsigned(mem_unsigned), .i_reg_write(reg_write), .i_mem_to_reg(mem_to_reg),
    .o_fwd_alu_res(o_fwd_alu_res), .o_fwd_reg_add(o_fwd_reg_add),
    .o_fwd_reg_write(o_fwd_reg_write), .o_valid(o_valid), .o_read_data(o_read_data),
    .o_alu_res(o_alu_res), .o_reg_add(o_reg_add), .o_reg_write(o_reg_write),
    .o_mem_to_reg(o_mem_to_reg), .o_misaligned(o_misaligned)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid, rd, wr;
    logic [1:0]  w;
    logic        uns, rw, m2r;
    logic [31:0] alu, sd;
    logic [4:0]  dst;
  } op_t;

  typedef struct packed {
    logic        valid, rw, m2r, mis;
    logic [31:0] rdata, alu;
    logic [4:0]  dst;
  } wb_t;

  logic [7:0] mem_m [0:1023];   // byte-addressed, 2**(8+2) bytes
  op_t exm = '0;
  wb_t wbm = '0;

  // Performs one memory operation on the byte array and returns the write-back record for it.
  task automatic execute(input op_t o, output wb_t r);
    int size;
    int a;
    logic [31:0] v;
    bit mis;
    size = (o.w == 2'b00) ? 1 : (o.w == 2'b01) ? 2 : 4;
    a    = int'(o.alu[9:0]);
    mis  = o.valid && (o.rd || o.wr) && (a % size != 0);
    r       = '0;
    r.valid = o.valid;
    r.alu   = o.alu;
    r.dst   = o.dst;
    r.m2r   = o.valid && o.m2r;
    r.rw    = o.valid && o.rw && !mis;
    r.mis   = mis;
    if (o.valid && o.wr && !mis)
      for (int i = 0; i < size; i++) mem_m[a+i] = o.sd[8*i +: 8];
    if (o.valid && o.rd && !mis) begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[a+i];
      if (!o.uns && size < 4 && v[8*size-1])
        for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
      r.rdata = v;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm = '0;
      wbm = '0;
    end else if (!stall) begin
      execute(exm, wbm);
      if (flush) begin
        exm = '0;
      end else begin
        exm.valid = valid;     exm.rd  = mem_read;   exm.wr  = mem_write;
        exm.w     = mem_width; exm.uns = mem_unsigned;
        exm.rw    = reg_write; exm.m2r = mem_to_reg;
        exm.alu   = alu_res;   exm.sd  = store_data; exm.dst = reg_add;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("o_valid",         32'(o_valid),         32'(wbm.valid));
      chk("o_reg_write",     32'(o_reg_write),     32'(wbm.rw));
      chk("o_misaligned",    32'(o_misaligned),    32'(wbm.mis));
      chk("o_fwd_reg_write", 32'(o_fwd_reg_write), 32'(exm.valid & exm.rw));
      if (wbm.valid) begin
        chk("o_read_data",  o_read_data,        wbm.rdata);
        chk("o_alu_res",    o_alu_res,          wbm.alu);
        chk("o_reg_add",    32'(o_reg_add),     32'(wbm.dst));
        chk("o_mem_to_reg", 32'(o_mem_to_reg),  32'(wbm.m2r));
      end
      if (exm.valid) begin
        chk("o_fwd_alu_res", o_fwd_alu_res,      exm.alu);
        chk("o_fwd_reg_add", 32'(o_fwd_reg_add), 32'(exm.dst));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input bit rd, input bit wr, input logic [1:0] w,
                       input bit uns, input bit rw, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] dst);
    valid = v; mem_read = rd; mem_write = wr; mem_width = w; mem_unsigned = uns;
    reg_write = rw; mem_to_reg = rd; alu_res = addr; store_data = sd; reg_add = dst;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents one op. It then waits the two edges until that op's write-back slot is on the outputs.
  task automatic run(input bit rd, input bit wr, input logic [1:0] w, input bit uns,
                     input logic [31:0] addr, input logic [31:0] sd);
    drive(1'b1, rd, wr, w, uns, rd, addr, sd, 5'd7);
    step();
    idle();
    step();
  endtask

  task automatic ld(input logic [31:0] addr, input logic [1:0] w, input bit uns);
    run(1'b1, 1'b0, w, uns, addr, 32'h0);
  endtask

  task automatic st(input logic [31:0] addr, input logic [1:0] w, input logic [31:0] d);
    run(1'b0, 1'b1, w, 1'b0, addr, d);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle();
    stall = 1'b0;
    flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset o_valid",         32'(o_valid),         32'd0);
    chk("reset o_read_data",     o_read_data,          32'd0);
    chk("reset o_reg_write",     32'(o_reg_write),     32'd0);
    chk("reset o_fwd_reg_write", 32'(o_fwd_reg_write), 32'd0);
    chk("reset o_misaligned",    32'(o_misaligned),    32'd0);
    repeat (2) step();
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Fill words 0..63 with known values, back to back.
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'(i*4), 32'h1000_0000 + 32'(i), 5'd0);
      step();
    end
    idle();
    repeat (2) step();

    // Word store and load
    st(32'h10, 2'b11, 32'hDEADBEEF);
    ld(32'h10, 2'b11, 1'b0);
    chk("lw 0x10 data",      o_read_data,      32'hDEADBEEF);
    chk("lw 0x10 reg_write", 32'(o_reg_write), 32'd1);

    // Sub-word loads and extension
    st(32'h20, 2'b11, 32'h80FF7F01);
    ld(32'h23, 2'b00, 1'b0); chk("lb 0x23",  o_read_data, 32'hFFFFFF80);
    ld(32'h23, 2'b00, 1'b1); chk("lbu 0x23", o_read_data, 32'h00000080);
    ld(32'h20, 2'b01, 1'b0); chk("lh 0x20",  o_read_data, 32'h00007F01);
    ld(32'h22, 2'b01, 1'b1); chk("lhu 0x22", o_read_data, 32'h000080FF);
    ld(32'h22, 2'b10, 1'b0); chk("width10 misaligned", 32'(o_misaligned), 32'd1);

    // Sub-word stores
    st(32'h30, 2'b11, 32'h11223344);
    st(32'h31, 2'b00, 32'h000000AA);
    ld(32'h30, 2'b11, 1'b0); chk("sb merge", o_read_data, 32'h1122AA44);
    st(32'h32, 2'b01, 32'h00005566);
    ld(32'h30, 2'b11, 1'b0); chk("sh merge", o_read_data, 32'h5566AA44);

    // Misaligned accesses
    ld(32'h0E, 2'b11, 1'b0);
    chk("lw 0x0E misaligned", 32'(o_misaligned), 32'd1);
    chk("lw 0x0E reg_write",  32'(o_reg_write),  32'd0);
    st(32'h11, 2'b01, 32'h0000FFFF);
    chk("sh 0x11 misaligned", 32'(o_misaligned), 32'd1);
    ld(32'h10, 2'b11, 1'b0); chk("word after bad sh", o_read_data, 32'hDEADBEEF);

    // Stall for three cycles while a store sits in EX/MEM. Flush and new EX inputs must be ignored.
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h10, 32'h0, 5'd3);
    step();
    drive(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h40, 32'h12345678, 5'd0);
    step();
    chk("pre-stall data", o_read_data, 32'hDEADBEEF);
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h44, 32'h0, 5'd9);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall data",    o_read_data,   32'hDEADBEEF);
      chk("stall valid",   32'(o_valid),  32'd1);
      chk("stall fwd alu", o_fwd_alu_res, 32'h40);
    end
    stall = 1'b0;
    flush = 1'b0;
    idle();
    step();
    chk("store after stall reg_write", 32'(o_reg_write), 32'd0);
    ld(32'h40, 2'b11, 1'b0); chk("stalled store data", o_read_data, 32'h12345678);

    // Flush turns the EX op into a bubble
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h10, 32'h0, 5'd4);
    step();
    flush = 1'b0;
    chk("flush fwd_reg_write", 32'(o_fwd_reg_write), 32'd0);
    idle();
    step();
    chk("flush o_valid",     32'(o_valid),     32'd0);
    chk("flush o_reg_write", 32'(o_reg_write), 32'd0);

    // Reset with a load in WB and a store in EX/MEM
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h10, 32'h0, 5'd5);
    step();
    drive(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h50, 32'hCAFEF00D, 5'd0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async reset o_valid",       32'(o_valid),     32'd0);
    chk("async reset o_read_data",   o_read_data,      32'd0);
    chk("async reset o_reg_write",   32'(o_reg_write), 32'd0);
    chk("async reset o_fwd_alu_res", o_fwd_alu_res,    32'd0);
    idle();
    step();
    rst_n = 1'b1;
    step();
    ld(32'h50, 2'b11, 1'b0); chk("store dropped by reset", o_read_data, 32'h10000014);

    // Randomized traffic on words 0..63. Upper address bits are random to exercise the wrap.
    for (int n = 0; n < 3000; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      drive($urandom_range(0, 9) != 0, kind == 0, kind == 1, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), (kind != 1) && ($urandom_range(0, 3) != 0),
            ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 255)), $urandom,
            5'($urandom_range(0, 31)));
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 11) == 0);
      step();
    end
    stall = 1'b0;
    flush = 1'b0;
    idle();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
